// File: rtl/fetch_control_unit.sv
// Fetch-stage control: merges stall sources and exc/eret/branch redirects,
// deferring a redirect that arrives during a stall until the stall drops.
module fetch_control_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        md_busy,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        stall,
  output logic        flush,
  output logic        jump_enable,
  output logic [31:0] jump_address,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pend_addr;
  logic        pend_eret;
  logic [15:0] cnt_q;

  logic        redirect;
  logic [31:0] redirect_addr;

  // Handshake with fetch: stall=1 freezes PC and IF/ID; jump_enable=1 with
  // stall=0 loads jump_address at the next edge; flush=1 zeroes IF/ID.
  assign stall         = (hazard_stall | md_busy) & ~exc_req & ~rst;
  assign redirect      = eret_req | branch_taken;
  assign redirect_addr = eret_req ? epc : branch_target;
  assign state         = state_q;
  assign stall_cycles  = cnt_q;

  always_comb begin
    jump_enable  = 1'b0;
    jump_address = 32'h0;
    flush        = 1'b0;
    if (!rst) begin
      if (exc_req) begin
        jump_enable  = 1'b1;
        jump_address = EXC_VECTOR;
        flush        = 1'b1;
      end else if (state_q == PENDING) begin
        // Live eret/branch inputs are ignored on the release cycle.
        if (!stall) begin
          jump_enable  = 1'b1;
          jump_address = pend_addr;
          flush        = pend_eret;
        end
      end else if (!stall && redirect) begin
        jump_enable  = 1'b1;
        jump_address = redirect_addr;
        flush        = eret_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pend_addr <= 32'h0;
      pend_eret <= 1'b0;
      cnt_q     <= 16'h0;
    end else begin
      if (stall && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
      if (exc_req) begin
        state_q   <= RUN;
        pend_addr <= 32'h0;
        pend_eret <= 1'b0;
      end else begin
        case (state_q)
          RUN, HOLD: begin
            if (stall) begin
              if (redirect) begin
                state_q   <= PENDING;
                pend_addr <= redirect_addr;
                pend_eret <= eret_req;
              end else begin
                state_q <= HOLD;
              end
            end else begin
              state_q <= RUN;
            end
          end
          PENDING: begin
            if (stall) begin
              // eret wins over a held branch; a new branch never replaces the entry.
              if (eret_req) begin
                pend_addr <= epc;
                pend_eret <= 1'b1;
              end
            end else begin
              state_q   <= RUN;
              pend_addr <= 32'h0;
              pend_eret <= 1'b0;
            end
          end
          default: begin
            state_q   <= RUN;
            pend_addr <= 32'h0;
            pend_eret <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_control_unit.md
FETCH_CONTROL_UNIT -- requirements
Module: fetch_control_unit

Interface
REQ-001 Parameter: EXC_VECTOR, 32'h0000_4180, exception handler address.
REQ-002 Ports: clk  in  1  single clock, all state updates on posedge; rst  in  1  synchronous, active-high reset.
REQ-003 Ports: hazard_stall  in  1  load-use stall request from decode.
REQ-004 Ports: md_busy  in  1  mul/div unit busy.
REQ-005 Ports: branch_taken  in  1, branch_target  in  32  branch/jump redirect from decode.
REQ-006 Ports: exc_req  in  1  exception; eret_req  in  1, epc  in  32  return redirect.
REQ-007 Ports: stall  out  1, flush  out  1, jump_enable  out  1, jump_address  out  32  fetch-stage controls.
REQ-008 Ports: state  out  2  (RUN=0, HOLD=1, PENDING=2); stall_cycles  out  16  performance counter.

Function
REQ-009 Fetch-stage contract: stall=1 freezes PC and IF/ID; jump_enable=1 with stall=0 loads jump_address into PC at next edge; flush=1 zeroes IF/ID instruction at next edge.
REQ-010 Redirect selection, priority: exc_req (EXC_VECTOR) > eret_req (epc) > branch_taken (branch_target).
REQ-011 stall = (hazard_stall | md_busy) & !exc_req & !rst, combinational, same cycle.
REQ-012 exc_req overrides both stall sources: stall=0, jump_enable=1, jump_address=EXC_VECTOR, flush=1, same cycle, any state; pending register cleared; next state RUN.
REQ-013 RUN, stall=0: any redirect drives jump_enable=1 and jump_address combinationally; flush=1 only for exc/eret (branch delay slot kept); stays RUN.
REQ-014 RUN, stall=1, no redirect: next state HOLD; RUN, stall=1 with eret/branch: latch address and kind into pending register, next state PENDING; jump_enable=0.
REQ-015 HOLD: stall=1 keeps HOLD; redirect during stall -> PENDING with latch; stall=0 -> RUN, with same-cycle redirect handled as REQ-013.
REQ-016 PENDING: jump_enable=0 while stall=1; eret_req overrides a pending branch; a later branch_taken never overwrites a pending entry.
REQ-017 PENDING, stall=0: jump_enable=1, jump_address=pending address for exactly one cycle, flush=1 iff pending kind is eret; pending cleared; next state RUN; new eret/branch inputs that cycle ignored.
REQ-018 jump_address=0 whenever jump_enable=0; flush=0 when no exc/eret applied.
REQ-019 stall_cycles increments by 1 each cycle stall=1, saturates at 16'hFFFF, never wraps.
REQ-020 state reflects registered FSM state; no other states reachable; illegal encoding recovers to RUN next cycle.

Reset
REQ-021 rst=1 at an edge: state RUN, pending cleared, stall_cycles 0, regardless of inputs, including mid-PENDING.
REQ-022 While rst=1: stall=0, flush=0, jump_enable=0, jump_address=0.
REQ-023 First cycle after reset release evaluates inputs normally.

Verification
REQ-024 RUN, branch_taken=1, target 32'h0000_3040, no stall -> same cycle jump_enable=1, jump_address=32'h0000_3040, flush=0, state stays 0.
REQ-025 hazard_stall=1 3 cycles, branch_taken=1 target 32'h0000_3100 in cycle 1 -> stall=1 3 cycles, jump_enable=0, state 2; cycle 4 jump_enable=1 addr 32'h0000_3100, then state 0; stall_cycles=3.
REQ-026 PENDING branch 32'h0000_3100, md_busy=1, eret_req=1 epc 32'h0000_3204 -> on release jump_address=32'h0000_3204, flush=1, one cycle.
REQ-027 md_busy=1 with exc_req=1 in PENDING -> stall=0, jump_enable=1, jump_address=32'h0000_4180, flush=1; next cycle state 0, no stale redirect emitted.
REQ-028 rst=1 in PENDING -> next cycle state 0, stall_cycles 0; after release stall=0 no jump_enable.
REQ-029 md_busy held 70000 cycles -> stall_cycles saturates at 16'hFFFF.
